uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart_tx_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: valid/ready push side, tx_req/tx_cts pop side.
// Optional LF -> CR LF expansion when UART_TX_FIFO_CRLF_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned depth = 16,
  localparam int unsigned level_bits = $clog2(depth) + 1
) (
  input  logic                  ser_clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  tx_cts,
  output logic [7:0]            tx_data,
  output logic                  tx_req,
  output logic [level_bits-1:0] level,
  output logic                  empty
);

  localparam int unsigned ptr_bits = $clog2(depth);
  localparam logic [level_bits-1:0] LevelFull = level_bits'(depth);

  logic [7:0]            r_mem [depth];
  logic [ptr_bits-1:0]   r_rd_ptr;
  logic [ptr_bits-1:0]   r_wr_ptr;
  logic [level_bits-1:0] r_level;

  logic       w_push;
  logic       w_pop;
  logic       w_wr_en;
  logic [7:0] w_wr_data;

  assign empty   = (r_level == '0);
  assign tx_req  = !empty;
  assign tx_data = empty ? 8'hFF : r_mem[r_rd_ptr];
  assign level   = r_level;
  assign w_push  = in_valid && in_ready;
  assign w_pop   = tx_req && tx_cts;

`ifdef UART_TX_FIFO_CRLF_EN
  logic r_lf_pending;
  logic w_lf_pending_d;
  logic w_lf_fits;

  // An LF needs room for both the CR and the LF it expands into.
  assign w_lf_fits = (in_data != 8'h0A) || (r_level <= LevelFull - level_bits'(2));
  assign in_ready  = (r_level != LevelFull) && !r_lf_pending && w_lf_fits;

  always_comb begin
    w_wr_en        = 1'b0;
    w_wr_data      = in_data;
    w_lf_pending_d = r_lf_pending;
    if (r_lf_pending) begin
      if (r_level != LevelFull) begin
        w_wr_en        = 1'b1;
        w_wr_data      = 8'h0A;
        w_lf_pending_d = 1'b0;
      end
    end else if (w_push) begin
      w_wr_en = 1'b1;
      if (in_data == 8'h0A) begin
        w_wr_data      = 8'h0D;
        w_lf_pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ser_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lf_pending <= 1'b0;
    end else begin
      r_lf_pending <= w_lf_pending_d;
    end
  end
`else
  assign in_ready  = (r_level != LevelFull);
  assign w_wr_en   = w_push;
  assign w_wr_data = in_data;
`endif

  // Storage is not reset; contents are only visible through level-qualified reads.
  always_ff @(posedge ser_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  always_ff @(posedge ser_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + ptr_bits'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ptr_bits'(1);
      end
      unique case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + level_bits'(1);
        2'b01:   r_level <= r_level - level_bits'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, directed sequences and random traffic
// against a queue-based reference model.
module tb_uart_tx_fifo;

  localparam int unsigned Depth = 16;
`ifdef UART_TX_FIFO_CRLF_EN
  localparam bit Crlf = 1'b1;
`else
  localparam bit Crlf = 1'b0;
`endif

  logic       ser_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       tx_cts = 1'b0;
  logic       in_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [4:0] level;
  logic       empty;

  uart_tx_fifo #(.depth(Depth)) u_dut (
    .ser_clk  (ser_clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_cts   (tx_cts),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .level    (level),
    .empty    (empty)
  );

  always #5 ser_clk = ~ser_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  bit         model_pend = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       cts;
    logic       exp_ready;
    logic       exp_req;
    logic [7:0] exp_data;
    logic [4:0] exp_level;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, compare against the model, advance the model at posedge.
  task automatic step(input bit v, input logic [7:0] d, input bit cts, output bit acc);
    int         lvl;
    bit         e_ready;
    bit         e_req;
    logic [7:0] e_data;
    bit         pop;
    in_valid = v;
    in_data  = d;
    tx_cts   = cts;
    #1;
    lvl     = model_q.size();
    e_ready = (lvl < Depth) && !model_pend && (!Crlf || d != 8'h0A || lvl <= Depth - 2);
    e_req   = (lvl != 0);
    e_data  = (lvl != 0) ? model_q[0] : 8'hFF;
    chk("in_ready", 32'(in_ready), 32'(e_ready));
    chk("tx_req", 32'(tx_req), 32'(e_req));
    chk("tx_data", 32'(tx_data), 32'(e_data));
    chk("level", 32'(level), 32'(lvl));
    chk("empty", 32'(empty), 32'(lvl == 0));
    acc = v && e_ready;
    pop = e_req && cts;
    if (pop) got_q.push_back(tx_data);
    @(posedge ser_clk);
    if (pop) void'(model_q.pop_front());
    if (model_pend) begin
      model_q.push_back(8'h0A);
      model_pend = 1'b0;
    end
    if (acc) begin
      if (Crlf && d == 8'h0A) begin
        model_q.push_back(8'h0D);
        model_pend = 1'b1;
      end else begin
        model_q.push_back(d);
      end
    end
    @(negedge ser_clk);
  endtask

  // Hold in_valid/in_data until taken; returns how many cycles it was refused.
  task automatic push_byte(input logic [7:0] d, output int waits);
    bit acc;
    waits = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, d, 1'b0, acc);
      if (acc) break;
      waits++;
    end
    if (waits >= 50) chk("push_timeout", 32'(waits), 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 200; i++) begin
      if (model_q.size() == 0 && !model_pend) break;
      step(1'b0, 8'h00, 1'b1, acc);
    end
    tx_cts = 1'b0;
    #1;
    chk("drained_empty", 32'(empty), 32'd1);
  endtask

  task automatic chk_seq(input string name);
    chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk(name, 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    bit acc;
    bit holding;
    int waits;
    int next_b;
    logic [7:0] rdata;

    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 5'd0};
    vecs[1] = '{1'b1, 8'h48, 1'b0, 1'b1, 1'b0, 8'hFF, 5'd0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h48, 5'd1};
    vecs[3] = '{1'b1, 8'h49, 1'b1, 1'b1, 1'b1, 8'h48, 5'd1};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h49, 5'd1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h49, 5'd1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 5'd0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 5'd0};

    #2;
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'hFF);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge ser_clk);
    #3 rst_n = 1'b1;
    @(negedge ser_clk);

    // Table: first push latency, push+pop at level 1, tx_cts while empty.
    for (int i = 0; i < 8; i++) begin
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      tx_cts   = vecs[i].cts;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_req", i), 32'(tx_req), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_level == 0));
      @(posedge ser_clk);
      @(negedge ser_clk);
    end

    // Fill to full; a 17th byte is refused.
    for (int i = 1; i <= 16; i++) push_byte(8'(i), waits);
    step(1'b1, 8'h11, 1'b0, acc);
    #1;
    chk("full_level", 32'(level), 32'd16);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    // Pop from full with a push offered: the push must not be taken that cycle.
    got_q.delete();
    step(1'b1, 8'h11, 1'b1, acc);
    #1;
    chk("after_pop_data", 32'(tx_data), 32'h02);
    chk("after_pop_level", 32'(level), 32'd15);
    chk("after_pop_ready", 32'(in_ready), 32'd1);
    push_byte(8'h11, waits);
    chk("after_pop_push_waits", 32'(waits), 32'd0);
    drain();
    exp_q.delete();
    exp_q.push_back(8'h01);
    for (int i = 2; i <= 17; i++) exp_q.push_back(8'(i));
    chk_seq("full_seq");

    // Stream 40 bytes through a transmitter that accepts once every 10 cycles.
    got_q.delete();
    exp_q.delete();
    for (int b = 0; b < 40; b++) begin
      if (Crlf && b == 8'h0A) begin
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
      end else begin
        exp_q.push_back(8'(b));
      end
    end
    next_b  = 0;
    holding = 1'b0;
    for (int c = 0; c < 1500 && got_q.size() < exp_q.size(); c++) begin
      if (!holding) holding = (next_b < 40) && ($urandom_range(0, 3) != 0);
      step(holding, 8'(next_b), (c % 10) == 9, acc);
      if (acc) begin
        next_b++;
        holding = 1'b0;
      end
    end
    in_valid = 1'b0;
    chk_seq("stream_seq");

    // Random traffic with the producer holding each offered byte until taken.
    holding = 1'b0;
    rdata   = 8'h00;
    for (int c = 0; c < 400; c++) begin
      if (!holding) begin
        holding = ($urandom_range(0, 1) != 0);
        rdata   = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) rdata = 8'h0A;
      end
      step(holding, rdata, $urandom_range(0, 2) == 0, acc);
      if (acc) holding = 1'b0;
    end
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with bytes queued.
    for (int i = 0; i < 5; i++) push_byte(8'(8'h31 + i), waits);
    in_valid = 1'b0;
    tx_cts   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_req", 32'(tx_req), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'hFF);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    model_q.delete();
    model_pend = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge ser_clk);
    got_q.delete();
    push_byte(8'h21, waits);
    drain();
    exp_q.delete();
    exp_q.push_back(8'h21);
    chk_seq("post_rst_seq");

    // LF handling.
    got_q.delete();
    push_byte(8'h6F, waits);
    push_byte(8'h0A, waits);
    push_byte(8'h21, waits);
    chk("lf_ready_gap", 32'(waits), Crlf ? 32'd1 : 32'd0);
    drain();
    exp_q.delete();
    exp_q.push_back(8'h6F);
    if (Crlf) exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    exp_q.push_back(8'h21);
    chk_seq("lf_seq");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
